pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Controls the program-counter register: owns the PC value and decides when and how it advances.
//  Issues instruction-memory fetches with a req/ready + rvalid handshake and presents each fetched
//  instruction to the core until the core signals completion. Selects the next PC (PC+4 or a
//  branch/jump redirect), enforces 4-byte alignment, and supports halt/resume and fetch timeout.
// PARAMETERS
//  WIDTH        32          PC / address width in bits
//  RESET_VEC    32'h0       PC value loaded on reset (bits [1:0] must be 0)
//  TIMEOUT      16          max cycles in WAIT before fetch-timeout error (>=1)
//  CNT_W        32          width of retire counter
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        asynchronous reset, active-high
//  imem_req        out  1        fetch request valid
//  imem_addr       out  WIDTH    fetch address (= pc)
//  imem_ready      in   1        memory accepts request this cycle
//  imem_rvalid     in   1        fetch data valid
//  imem_rdata      in   32       fetched instruction word
//  instr_valid     out  1        instr/instr_pc valid to core
//  instr           out  32       current instruction (registered)
//  instr_pc        out  WIDTH    PC of current instruction
//  exec_done       in   1        core finished current instruction (sampled only in EXEC)
//  redirect_valid  in   1        taken branch/jump; qualifies redirect_target with exec_done
//  redirect_target in   WIDTH    next PC when redirect_valid
//  halt_req        in   1        halt after current instruction retires
//  resume          in   1        leave HALT
//  halted          out  1        in HALT state
//  err             out  1        sticky error (misaligned target or fetch timeout)
//  err_cause       out  2        00 none, 01 misaligned target, 10 fetch timeout
//  retire_count    out  CNT_W    instructions retired since reset, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async): state=BOOT, pc=RESET_VEC, instr=0, instr_pc=0, retire_count=0, timer=0,
//   err=0, err_cause=00; all outputs 0 except imem_addr=RESET_VEC.
//  FSM states BOOT, REQ, WAIT, EXEC, HALT, ERR:
//   BOOT: one cycle after reset deasserts -> REQ (no request issued in BOOT).
//   REQ : imem_req=1, imem_addr=pc; imem_ready=1 -> WAIT (timer cleared); else stay.
//   WAIT: imem_req=0; imem_rvalid=1 -> instr<=imem_rdata, instr_pc<=pc, -> EXEC.
//         rvalid=0: timer++; timer reaching TIMEOUT-1 without rvalid -> ERR, err_cause=10.
//         rvalid in the same cycle as the timeout takes priority (no error).
//   EXEC: instr_valid=1, stable until exec_done. On exec_done:
//         tgt = redirect_valid ? redirect_target : pc+4 (mod 2^WIDTH, wraps silently).
//         tgt[1:0]!=0 -> ERR, err_cause=01, pc unchanged, no retire.
//         else pc<=tgt, retire_count++, then halt_req ? HALT : REQ.
//         redirect_valid without exec_done is ignored.
//   HALT: halted=1, no fetch; resume=1 -> REQ. halt_req ignored outside EXEC.
//   ERR : err=1, all handshakes idle; sticky until reset.
//  Latency: REQ->EXEC is 2 cycles minimum (ready on first REQ cycle, rvalid on first WAIT cycle);
//   exec_done -> next imem_req is 1 cycle.
//  imem_rvalid outside WAIT is ignored; memory returns at most one response per accepted request.
//  Reset mid-operation: async reset aborts any in-flight fetch; a late rvalid after reset is
//   ignored (arrives in BOOT/REQ).
// TESTING
//  T1 reset, ready=1, rvalid 1 cycle later, exec_done each EXEC -> imem_addr 0,4,8,C; retire_count=3 at 4th fetch.
//  T2 at pc=8, exec_done with redirect_valid, target=0x40 -> next imem_addr=0x40, instr_pc=0x40.
//  T3 redirect_target=0x42 -> err=1, err_cause=01, pc stays 8, retire_count unchanged, imem_req stays 0.
//  T4 rvalid withheld, TIMEOUT=16 -> err_cause=10 after 16 WAIT cycles; rvalid in that cycle -> no error.
//  T5 halt_req with exec_done at pc=4 -> halted=1, no imem_req; resume -> imem_req with addr=8.
//  T6 reset asserted in WAIT, then rvalid -> instr unchanged (0); BOOT then REQ at RESET_VEC.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch bus and core-side handshake bundle for pc_sequencer.
// master: sequencer side; slave: memory/core side.
interface pc_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [WIDTH-1:0] instr_pc;
  logic             exec_done;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             halt_req;
  logic             resume;
  logic             halted;
  logic             err;
  logic [1:0]       err_cause;
  logic [CNT_W-1:0] retire_count;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata,
    output instr_valid,
    output instr,
    output instr_pc,
    input  exec_done,
    input  redirect_valid,
    input  redirect_target,
    input  halt_req,
    input  resume,
    output halted,
    output err,
    output err_cause,
    output retire_count
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output exec_done,
    output redirect_valid,
    output redirect_target,
    output halt_req,
    output resume,
    input  halted,
    input  err,
    input  err_cause,
    input  retire_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the PC, fetches via req/ready + rvalid,
// holds the instruction for the core, selects PC+4 or redirect.
// Ports: clk, reset (async, active-high), bus (pc_sequencer_if.master):
//   imem_* fetch bus, instr_* to core, exec_done/redirect_*,
//   halt_req/resume/halted, err/err_cause, retire_count.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               TIMEOUT   = 16,
  parameter int               CNT_W     = 32
) (
  input  logic clk,
  input  logic reset,
  pc_sequencer_if.master bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_WAIT,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [WIDTH-1:0] ipc_q, ipc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             err_q, err_d;
  logic [1:0]       cause_q, cause_d;
  logic [WIDTH-1:0] tgt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VEC;
      instr_q <= '0;
      ipc_q   <= '0;
      ret_q   <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ret_q   <= ret_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  // Next PC candidate; the +4 wraps modulo 2^WIDTH.
  assign tgt = bus.redirect_valid ? bus.redirect_target
                                  : pc_q + WIDTH'(4);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ret_d   = ret_q;
    tmr_d   = tmr_q;
    err_d   = err_q;
    cause_d = cause_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (bus.imem_ready) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end
      end
      S_WAIT: begin
        // A response in the last allowed cycle still wins.
        if (bus.imem_rvalid) begin
          instr_d = bus.imem_rdata;
          ipc_d   = pc_q;
          state_d = S_EXEC;
        end else if (tmr_q == T_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
          cause_d = 2'b10;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (tgt[1:0] != 2'b00) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            cause_d = 2'b01;
          end else begin
            pc_d    = tgt;
            ret_d   = ret_q + CNT_W'(1);
            state_d = bus.halt_req ? S_HALT : S_REQ;
          end
        end
      end
      S_HALT: begin
        if (bus.resume) state_d = S_REQ;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign bus.imem_req     = (state_q == S_REQ);
  assign bus.imem_addr    = pc_q;
  assign bus.instr_valid  = (state_q == S_EXEC);
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = ipc_q;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.err          = err_q;
  assign bus.err_cause    = cause_q;
  assign bus.retire_count = ret_q;

endmodule
